// File: rtl/apb_adc_mc_fifo_pkg.sv
// apb_adc_pkg: register map and field positions for the multi-channel ADC capture block
package apb_adc_pkg;
  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_STATUS  = 2'd1,
    ADDR_CTRL    = 2'd2,
    ADDR_OVF_CLR = 2'd3
  } reg_addr_e;
  localparam int DATA_VALID_BIT  = 31;
  localparam int DATA_CH_LSB     = 16;
  localparam int ST_EMPTY_BIT    = 8;
  localparam int ST_FULL_BIT     = 9;
  localparam int ST_OVF_LSB      = 16;
  localparam int CTRL_THRESH_LSB = 16;
  localparam int CTRL_IRQ_EN_BIT = 24;
  localparam int CTRL_FLUSH_BIT  = 25;
endpackage

// File: rtl/apb_adc_mc_fifo_if.sv
// apb_adc_mc_fifo_if: APB3 slave bus bundle
interface apb_adc_mc_fifo_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [3:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA, PREADY, PSLVERR);
  modport slave (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_adc_mc_fifo_sync_fifo.sv
// adc_sync_fifo: show-ahead synchronous FIFO with level count and flush
module adc_sync_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign empty   = level == '0;
  assign full    = level == LW'(DEPTH);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr];
  // pointers and level; flush has priority over push/pop
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop) rptr <= rptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end
  // storage; a full push with pop overwrites the slot being read out this cycle
  always_ff @(posedge clk) begin
    if (rst_n && do_push && !flush) mem[wptr] <= din;
  end
endmodule

// File: rtl/apb_adc_mc_fifo.sv
// apb_adc_mc_fifo: multi-channel ADC capture with round-robin merge into an APB-readable FIFO
module apb_adc_mc_fifo
  import apb_adc_pkg::*;
#(
  parameter int NCH = 4,
  parameter int ADC_W = 12,
  parameter int FIFO_DEPTH = 16,
  localparam int CH_W = NCH > 1 ? $clog2(NCH) : 1,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  apb_adc_mc_fifo_if.slave     apb,
  input  logic [NCH*ADC_W-1:0] ADC_DATA,
  input  logic [NCH-1:0]       ADC_VALID,
  output logic                 IRQ
);
  reg_addr_e addr;
  logic rd, wr, ctrl_wr, clr_wr, push, pop, full, empty, gnt_v, irq_en, flush, irq_en_n, unused_bits;
  logic [NCH-1:0] ch_en, ovf, hold_v, cap, drain, ovf_n, hold_v_n, ch_en_n;
  logic [ADC_W-1:0] hold [NCH];
  logic [CH_W-1:0] rr, gnt;
  logic [7:0] thresh, thresh_n;
  logic [LW-1:0] level, level_n;
  logic [CH_W+ADC_W-1:0] dout;
  logic [31:0] data_word, status_word, ctrl_word;
  int idx;
  assign addr        = reg_addr_e'(apb.PADDR[3:2]);
  assign rd          = apb.PSEL & apb.PENABLE & ~apb.PWRITE;
  assign wr          = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign ctrl_wr     = wr && addr == ADDR_CTRL;
  assign clr_wr      = wr && addr == ADDR_OVF_CLR;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = 1'b0;
  assign unused_bits = ^{apb.PADDR, apb.PWDATA};
  assign cap         = ADC_VALID & ch_en;
  assign pop         = rd && addr == ADDR_DATA && !empty && !flush;
  assign push        = gnt_v & ~flush & (~full | pop);
  assign drain       = push ? NCH'(1) << gnt : '0;
  assign hold_v_n    = (flush ? '0 : hold_v & ~drain) | cap;
  assign ovf_n       = (ovf & ~(clr_wr ? apb.PWDATA[NCH-1:0] : '0)) | (cap & hold_v & ~drain & {NCH{~flush}});
  assign level_n     = flush ? '0 : level + LW'(push) - LW'(pop);
  assign ch_en_n     = ctrl_wr ? apb.PWDATA[NCH-1:0] : ch_en;
  assign thresh_n    = ctrl_wr ? apb.PWDATA[CTRL_THRESH_LSB +: 8] : thresh;
  assign irq_en_n    = ctrl_wr ? apb.PWDATA[CTRL_IRQ_EN_BIT] : irq_en;
  // round-robin grant: first held channel at or after the priority pointer
  always_comb begin
    gnt   = '0;
    gnt_v = 1'b0;
    idx   = 0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = (int'(rr) + k) % NCH;
      if (hold_v[idx]) begin
        gnt   = CH_W'(idx);
        gnt_v = 1'b1;
      end
    end
  end
  adc_sync_fifo #(.WIDTH(CH_W + ADC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(PCLK), .rst_n(PRESETn), .push(push), .pop(pop), .flush(flush),
    .din({gnt, hold[gnt]}), .dout(dout), .level(level), .full(full), .empty(empty)
  );
  // control, sticky overflow, hold-valid, arbiter pointer and registered IRQ
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      ch_en  <= '0;
      thresh <= '0;
      irq_en <= 1'b0;
      flush  <= 1'b0;
      ovf    <= '0;
      hold_v <= '0;
      rr     <= '0;
      IRQ    <= 1'b0;
    end else begin
      ch_en  <= ch_en_n;
      thresh <= thresh_n;
      irq_en <= irq_en_n;
      flush  <= ctrl_wr & apb.PWDATA[CTRL_FLUSH_BIT];
      ovf    <= ovf_n;
      hold_v <= hold_v_n;
      if (push) rr <= gnt == CH_W'(NCH - 1) ? '0 : gnt + CH_W'(1);
      IRQ    <= irq_en_n & ((32'(level_n) >= 32'(thresh_n)) | (|ovf_n));
    end
  end
  // per-channel holding registers; a new strobe always overwrites
  always_ff @(posedge PCLK) begin
    for (int i = 0; i < NCH; i++) begin
      if (!PRESETn) hold[i] <= '0;
      else if (cap[i]) hold[i] <= ADC_DATA[i*ADC_W +: ADC_W];
    end
  end
  // read mux; DATA only reports valid when the head is actually popped
  always_comb begin
    data_word = '0;
    data_word[DATA_VALID_BIT] = 1'b1;
    data_word[DATA_CH_LSB +: CH_W] = dout[ADC_W +: CH_W];
    data_word[ADC_W-1:0] = dout[ADC_W-1:0];
    status_word = '0;
    status_word[LW-1:0] = level;
    status_word[ST_EMPTY_BIT] = empty;
    status_word[ST_FULL_BIT] = full;
    status_word[ST_OVF_LSB +: NCH] = ovf;
    ctrl_word = '0;
    ctrl_word[NCH-1:0] = ch_en;
    ctrl_word[CTRL_THRESH_LSB +: 8] = thresh;
    ctrl_word[CTRL_IRQ_EN_BIT] = irq_en;
    apb.PRDATA = !rd ? '0 :
                 addr == ADDR_DATA ? (pop ? data_word : '0) :
                 addr == ADDR_STATUS ? status_word :
                 addr == ADDR_CTRL ? ctrl_word : '0;
  end
endmodule

// File: tb/tb_apb_adc_mc_fifo.sv
// tb_apb_adc_mc_fifo: randomized scoreboard bench against a queue-based reference model
module tb_apb_adc_mc_fifo;
  localparam int NCH = 4, ADC_W = 12, DEPTH = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [NCH*ADC_W-1:0] adc_data;
  logic [NCH-1:0] adc_valid;
  logic irq;
  always #5 clk = ~clk;
  apb_adc_mc_fifo_if bus();
  apb_adc_mc_fifo dut (.PCLK(clk), .PRESETn(rst_n), .apb(bus), .ADC_DATA(adc_data), .ADC_VALID(adc_valid), .IRQ(irq));

  typedef struct { int ch; int val; } ent_t;
  ent_t q[$];
  logic [NCH-1:0] m_hv, m_en, m_ovf;
  int m_hd[NCH];
  int m_th, m_rr;
  bit m_ie, m_fl, m_irq, irq_now;
  logic [31:0] exp_q[$];
  string name_q[$];
  int total = 0, bad = 0;

  // one clock: drive inputs, record expected read data, advance the model across the edge
  task automatic tick(input bit r, input bit sel, input bit en, input bit w, input int a,
                      input logic [31:0] wd, input logic [NCH-1:0] v, input logic [NCH*ADC_W-1:0] d, input string nm);
    bit rd, pop, push;
    int g;
    logic [31:0] e;
    logic [NCH-1:0] capm;
    rst_n = r; bus.PSEL = sel; bus.PENABLE = en; bus.PWRITE = w; bus.PADDR = 4'(a << 2); bus.PWDATA = wd;
    adc_valid = v; adc_data = d;
    irq_now = m_irq;
    if (!r) begin
      q.delete(); m_hv = '0; m_en = '0; m_ovf = '0; m_th = 0; m_ie = 0; m_fl = 0; m_rr = 0; m_irq = 0;
      foreach (m_hd[i]) m_hd[i] = 0;
    end else begin
      rd = sel && en && !w;
      pop = rd && a == 0 && q.size() > 0 && !m_fl;
      if (rd) begin
        case (a)
          0: e = pop ? (32'h8000_0000 | (32'(q[0].ch) << 16) | 32'(q[0].val)) : 32'h0;
          1: e = 32'(q.size()) | (32'(q.size() == 0) << 8) | (32'(q.size() == DEPTH) << 9) | (32'(m_ovf) << 16);
          2: e = 32'(m_en) | (32'(m_th) << 16) | (32'(m_ie) << 24);
          default: e = 32'h0;
        endcase
        exp_q.push_back(e);
        name_q.push_back(nm);
      end
      g = -1;
      push = 0;
      capm = v & m_en;
      if (m_fl) begin
        q.delete();
        m_hv = '0;
      end else begin
        for (int k = 0; k < NCH; k++) if (g < 0 && m_hv[(m_rr + k) % NCH]) g = (m_rr + k) % NCH;
        push = g >= 0 && (q.size() < DEPTH || pop);
        if (pop) void'(q.pop_front());
        if (push) begin
          q.push_back('{g, m_hd[g]});
          m_hv[g] = 1'b0;
          m_rr = (g + 1) % NCH;
        end
      end
      if (sel && en && w && a == 3) m_ovf &= ~wd[NCH-1:0];
      for (int i = 0; i < NCH; i++) if (capm[i]) begin
        if (m_hv[i]) m_ovf[i] = 1'b1;
        m_hv[i] = 1'b1;
        m_hd[i] = int'(d[i*ADC_W +: ADC_W]);
      end
      m_fl = sel && en && w && a == 2 && wd[25];
      if (sel && en && w && a == 2) begin
        m_en = wd[NCH-1:0]; m_th = int'(wd[23:16]); m_ie = wd[24];
      end
      m_irq = m_ie && (q.size() >= m_th || m_ovf != 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic [NCH-1:0] v = '0, input logic [NCH*ADC_W-1:0] d = '0);
    for (int i = 0; i < n; i++) tick(1, 0, 0, 0, 0, 0, i == 0 ? v : '0, d, "");
  endtask
  task automatic do_rst();
    tick(0, 0, 0, 0, 0, 0, '0, '0, "");
  endtask
  task automatic rd(input int a, input string nm, input logic [NCH-1:0] v = '0, input logic [NCH*ADC_W-1:0] d = '0);
    tick(1, 1, 0, 0, a, 0, '0, '0, nm);
    tick(1, 1, 1, 0, a, 0, v, d, nm);
  endtask
  task automatic wr(input int a, input logic [31:0] wd, input logic [NCH-1:0] v = '0, input logic [NCH*ADC_W-1:0] d = '0);
    tick(1, 1, 0, 1, a, wd, '0, '0, "");
    tick(1, 1, 1, 1, a, wd, v, d, "");
  endtask

  // monitor: every read access pops the scoreboard; IRQ compared every cycle
  always @(negedge clk) begin
    logic [31:0] e;
    string n;
    if (bus.PSEL === 1'b1 && bus.PENABLE === 1'b1 && bus.PWRITE === 1'b0) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_read got=%h want=<none>", bus.PRDATA);
      end else begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (bus.PRDATA !== e) begin
          bad++;
          $display("FAIL %s got=%h want=%h t=%0t", n, bus.PRDATA, e, $time);
        end
      end
    end
    total++;
    if (irq !== irq_now) begin
      bad++;
      $display("FAIL irq got=%b want=%b t=%0t", irq, irq_now, $time);
    end
  end

  initial begin
    logic [NCH*ADC_W-1:0] d;
    bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = 0; bus.PWDATA = 0; adc_valid = 0; adc_data = 0;
    do_rst(); do_rst();
    rd(1, "rst_status"); rd(2, "rst_ctrl"); rd(0, "rst_data");
    wr(2, 32'h0000_000F);
    idle(3, 4'b0100, {12'h0, 12'hABC, 12'h0, 12'h0});
    rd(1, "single_level"); rd(0, "single_pop"); rd(0, "single_empty"); rd(1, "single_level0");
    do_rst();
    wr(2, 32'h0000_000F);
    idle(6, 4'b1111, {12'h103, 12'h102, 12'h101, 12'h100});
    rd(1, "all4_status");
    for (int i = 0; i < 4; i++) rd(0, "all4_pop");
    rd(1, "all4_noovf");
    for (int i = 0; i < 18; i++) idle(1, 4'b0010, 48'($urandom) << 12);
    idle(3);
    rd(1, "fill_status");
    wr(3, 32'h2);
    rd(1, "ovfclr_status");
    rd(0, "full_pop"); rd(1, "full_level"); idle(1);
    for (int i = 0; i < 18; i++) rd(0, "drain_pop");
    rd(1, "drained_status");
    wr(2, 32'h0103_000F);
    for (int i = 0; i < 3; i++) begin
      idle(3, 4'b0001, 48'($urandom));
      rd(1, "irq_level");
    end
    rd(0, "irq_pop"); idle(2);
    for (int i = 0; i < 5; i++) idle(2, 4'(1 << (i % 4)), 48'({$urandom, $urandom}));
    rd(1, "preflush_status");
    wr(2, 32'h0200_000F);
    rd(1, "flush_status"); rd(0, "flush_data");
    idle(1, 4'b1111, 48'({$urandom, $urandom}));
    idle(1, 4'b1111, 48'({$urandom, $urandom}));
    do_rst();
    rd(1, "reset_status"); rd(2, "reset_ctrl"); rd(0, "reset_data");
    wr(2, 32'h0104_000F);
    for (int it = 0; it < 2500; it++) begin
      int op;
      logic [NCH-1:0] v;
      op = $urandom_range(0, 99);
      v = 4'($urandom) & ($urandom_range(0, 2) == 0 ? 4'hF : 4'h0);
      d = 48'({$urandom, $urandom});
      if (op < 45) idle(1, v, d);
      else if (op < 75) rd(0, "rand_data", v, d);
      else if (op < 85) rd($urandom_range(1, 3), "rand_reg", v, d);
      else if (op < 92) wr(2, {6'b0, ($urandom_range(0, 9) == 0), 1'($urandom), 8'($urandom_range(0, 17)), 12'b0, 4'($urandom) | 4'b0011}, v, d);
      else if (op < 98) wr(3, 32'($urandom), v, d);
      else if (op < 99) do_rst();
      else idle(1);
      if (op == 99 && it % 3 == 0) wr(2, 32'h0102_000F);
    end
    idle(3);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/apb_adc_mc_fifo.md
Name: apb_adc_mc_fifo

Overview:
Multi-channel APB ADC capture block, successor to the single-channel 12-bit capture register. It samples NCH ADC channels on per-channel valid strobes and holds each sample in a per-channel holding register. A round-robin arbiter moves held samples into a shared sync FIFO tagged with their channel number. Software pops samples and reads status/control over APB3 from the PID controller's peripheral bus.

Parameters:
NCH, 4, number of ADC channels (1..16)
ADC_W, 12, sample width in bits (1..16)
FIFO_DEPTH, 16, FIFO entries, power of two, >=2
CH_W, $clog2(NCH) (min 1), channel tag width, derived, not overridden

Ports:
PCLK  in  1  APB clock; the only clock
PRESETn  in  1  synchronous active-low reset, sampled on PCLK rising edge
PSEL  in  1  APB select
PENABLE  in  1  APB enable
PWRITE  in  1  APB write
PADDR  in  4  byte address; bits [3:2] decoded, [1:0] ignored
PWDATA  in  32  APB write data
PRDATA  out  32  APB read data
PREADY  out  1  tied 1
PSLVERR  out  1  tied 0
ADC_DATA  in  NCH*ADC_W  flat sample bus; channel i at [i*ADC_W +: ADC_W]
ADC_VALID  in  NCH  per-channel one-cycle sample strobe
IRQ  out  1  level interrupt: (level >= THRESH) | ovf_any, gated by CTRL.irq_en

Behaviour:
- Clock PCLK only. Reset synchronous active-low on PRESETn. Reset clears: FIFO pointers/level, holding registers and their valid bits, sticky overflow bits, CTRL (ch_en=0, irq_en=0, thresh=0). PRDATA=0 and IRQ=0 after reset.
- Reset mid-operation discards all held and queued samples. No partial state survives.
- Register map (word offsets):
  - 0x0 DATA (R): bit31=valid, [16+CH_W-1:16]=channel, [ADC_W-1:0]=sample. Other bits 0.
  - 0x4 STATUS (R): [7:0]=level, bit8=empty, bit9=full, [31:16]=sticky per-channel overflow (bit 16+i).
  - 0x8 CTRL (R/W): [15:0]=ch_en mask, [23:16]=thresh, bit24=irq_en, bit25=flush (write-1 pulse, reads 0).
  - 0xC OVF_CLR (W): write-1-to-clear overflow bits from PWDATA[15:0]. Reads return 0.
- Access cycle = PSEL & PENABLE. PRDATA is combinational from state during the access cycle. PRDATA=0 outside access cycles and for write cycles.
- Pop: an access-cycle read of DATA with FIFO non-empty returns the head with valid=1 and advances the read pointer at that edge. Read of DATA when empty returns 0 (valid=0) and does not pop or underflow.
- Capture: ADC_VALID[i] & ch_en[i] at edge t loads hold[i] and sets hold_v[i]. Strobes on disabled channels are ignored.
- Capture when hold_v[i] is already set and not being drained this cycle: the new sample overwrites, and ovf[i] is set.
- Arbiter: round-robin over hold_v. At most one push per cycle. It pushes only when the FIFO is not full or a pop happens in the same cycle. The granted channel clears hold_v unless recaptured in the same cycle. Priority pointer moves to grant+1 (mod NCH).
- Latency: strobe at edge t -> held at t -> earliest in FIFO at t+1 -> readable from the next access cycle.
- Full FIFO with no pop: samples remain held. Further strobes on that channel overflow as above. The FIFO never drops entries.
- Simultaneous push and pop: level unchanged; allowed when full or empty. When empty, the pop sees an empty FIFO, returns valid=0, and the push still lands.
- Pointers wrap modulo FIFO_DEPTH. Level is $clog2(FIFO_DEPTH)+1 bits, zero-extended into STATUS.
- Flush: clears FIFO and hold_v in the cycle after the write edge. Sticky ovf bits are not cleared. A flush has priority over push and pop in that cycle.
- OVF_CLR in the same cycle as a new overflow on the same bit: set wins.
- IRQ is registered, updated every cycle from next-state level/ovf.

Decomposition:
- Package apb_adc_pkg: register offsets (ADDR_DATA/STATUS/CTRL/OVF_CLR), STATUS/CTRL bit positions, DATA valid/channel field positions.
- Sub-module adc_sync_fifo: params WIDTH=CH_W+ADC_W, DEPTH. Ports push/pop/din/dout/level/full/empty/flush. Synchronous active-low reset. Show-ahead head.
- Top holds the APB decode, CTRL/ovf registers, holding registers, arbiter and IRQ.

Test Plan:
- Reset, ch_en=0xF, single ADC_VALID[2] with 0xABC -> STATUS level=1; DATA read=0x8002_0ABC; next DATA read=0x0000_0000, level=0.
- All 4 channels strobed same cycle with 0x100+i -> four DATA reads return channels 0,1,2,3 in order, values 0x100..0x103, no ovf.
- Fill FIFO (16) with no reads, keep strobing ch1 twice more -> level=16, full=1, STATUS bit17 set, no entry lost. OVF_CLR 0x2 clears bit17 only.
- Level at full with pop and pending hold in the same cycle -> DATA returns oldest entry, level stays 16, next entry is the held sample.
- CTRL thresh=3, irq_en=1; push 2 samples -> IRQ=0; third -> IRQ=1 one cycle after level reaches 3; pop one -> IRQ=0.
- Flush with 5 queued, then PRESETn low for one cycle mid-burst -> level=0, empty=1, PRDATA=0, IRQ=0, CTRL back to 0.
